// File: rtl/ex_mem_pipeline_reg_if.sv
// EX/MEM boundary bundle: EX-side payload, stage controls and the registered MEM-side view.
// master drives the EX side; slave is the pipeline register itself.
interface ex_mem_pipeline_reg_if #(
    parameter int CNT_W = 16
);
    logic             Stall_MEM;
    logic             Flush_MEM;
    logic [31:0]      ALU_Result_EX;
    logic             Zero_EX;
    logic [31:0]      Write_Data_EX;
    logic [4:0]       Write_Register_EX;
    logic [31:0]      Branch_Target_EX;
    logic             RegWrite_EX;
    logic             MemtoReg_EX;
    logic             MemRead_EX;
    logic             MemWrite_EX;
    logic             Branch_EX;

    logic [31:0]      ALU_Result_MEM;
    logic             Zero_MEM;
    logic [31:0]      Write_Data_MEM;
    logic [4:0]       Write_Register_MEM;
    logic [31:0]      Branch_Target_MEM;
    logic             RegWrite_MEM;
    logic             MemtoReg_MEM;
    logic             MemRead_MEM;
    logic             MemWrite_MEM;
    logic             Branch_MEM;
    logic             Valid_MEM;
    logic             PCSrc_MEM;
    logic [CNT_W-1:0] Taken_Count;
    logic [CNT_W-1:0] Bubble_Count;

    modport master (
        output Stall_MEM, Flush_MEM, ALU_Result_EX, Zero_EX, Write_Data_EX,
               Write_Register_EX, Branch_Target_EX, RegWrite_EX, MemtoReg_EX,
               MemRead_EX, MemWrite_EX, Branch_EX,
        input  ALU_Result_MEM, Zero_MEM, Write_Data_MEM, Write_Register_MEM,
               Branch_Target_MEM, RegWrite_MEM, MemtoReg_MEM, MemRead_MEM,
               MemWrite_MEM, Branch_MEM, Valid_MEM, PCSrc_MEM, Taken_Count,
               Bubble_Count
    );

    modport slave (
        input  Stall_MEM, Flush_MEM, ALU_Result_EX, Zero_EX, Write_Data_EX,
               Write_Register_EX, Branch_Target_EX, RegWrite_EX, MemtoReg_EX,
               MemRead_EX, MemWrite_EX, Branch_EX,
        output ALU_Result_MEM, Zero_MEM, Write_Data_MEM, Write_Register_MEM,
               Branch_Target_MEM, RegWrite_MEM, MemtoReg_MEM, MemRead_MEM,
               MemWrite_MEM, Branch_MEM, Valid_MEM, PCSrc_MEM, Taken_Count,
               Bubble_Count
    );
endinterface

// File: rtl/ex_mem_pipeline_reg.sv
// EX/MEM pipeline register with stall/flush, branch resolution in MEM and
// saturating taken-branch / bubble counters.
module ex_mem_pipeline_reg #(
    parameter int CNT_W = 16
) (
    input logic                  Clk,
    input logic                  Reset,
    ex_mem_pipeline_reg_if.slave ex_mem
);
    typedef struct packed {
        logic [31:0] alu_result;
        logic        zero;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
        logic [31:0] branch_target;
        logic        reg_write;
        logic        memto_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        valid;
    } stage_t;

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             pcsrc;

    // Branch decision uses registered state only, so nothing from EX leaks through.
    assign pcsrc = stage_q.branch & stage_q.zero & stage_q.valid;

    always_comb begin
        stage_d      = stage_q;
        taken_cnt_d  = taken_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ex_mem.Flush_MEM) begin
            stage_d = '0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
        end else if (!ex_mem.Stall_MEM) begin
            stage_d.alu_result    = ex_mem.ALU_Result_EX;
            stage_d.zero          = ex_mem.Zero_EX;
            stage_d.write_data    = ex_mem.Write_Data_EX;
            stage_d.write_reg     = ex_mem.Write_Register_EX;
            stage_d.branch_target = ex_mem.Branch_Target_EX;
            stage_d.reg_write     = ex_mem.RegWrite_EX & (ex_mem.Write_Register_EX != 5'd0);
            stage_d.memto_reg     = ex_mem.MemtoReg_EX;
            stage_d.mem_read      = ex_mem.MemRead_EX;
            stage_d.mem_write     = ex_mem.MemWrite_EX;
            stage_d.branch        = ex_mem.Branch_EX;
            stage_d.valid         = 1'b1;
        end
        // A stalled taken branch is counted once, on the edge it leaves the stage.
        if (pcsrc && !ex_mem.Stall_MEM && taken_cnt_q != '1)
            taken_cnt_d = taken_cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stage_q      <= '0;
            taken_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            taken_cnt_q  <= taken_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_mem.ALU_Result_MEM     = stage_q.alu_result;
    assign ex_mem.Zero_MEM           = stage_q.zero;
    assign ex_mem.Write_Data_MEM     = stage_q.write_data;
    assign ex_mem.Write_Register_MEM = stage_q.write_reg;
    assign ex_mem.Branch_Target_MEM  = stage_q.branch_target;
    assign ex_mem.RegWrite_MEM       = stage_q.reg_write;
    assign ex_mem.MemtoReg_MEM       = stage_q.memto_reg;
    assign ex_mem.MemRead_MEM        = stage_q.mem_read;
    assign ex_mem.MemWrite_MEM       = stage_q.mem_write;
    assign ex_mem.Branch_MEM         = stage_q.branch;
    assign ex_mem.Valid_MEM          = stage_q.valid;
    assign ex_mem.PCSrc_MEM          = pcsrc;
    assign ex_mem.Taken_Count        = taken_cnt_q;
    assign ex_mem.Bubble_Count       = bubble_cnt_q;
endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// Bench for ex_mem_pipeline_reg: behavioural model compared every negedge plus
// directed vectors with literal expectations.
module tb_ex_mem_pipeline_reg;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic Clk;
    logic Reset;
    int   n_pass = 0;
    int   n_total = 0;

    ex_mem_pipeline_reg_if #(.CNT_W(CNT_W)) bus ();

    ex_mem_pipeline_reg #(.CNT_W(CNT_W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .ex_mem (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: what the MEM stage must hold, tracked as plain variables.
    logic [31:0] m_alu, m_wdata, m_btgt;
    logic [4:0]  m_wreg;
    logic        m_zero, m_rw, m_m2r, m_mr, m_mw, m_br, m_valid;
    int          m_taken, m_bubble;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            {m_alu, m_wdata, m_btgt, m_wreg} <= '0;
            {m_zero, m_rw, m_m2r, m_mr, m_mw, m_br, m_valid} <= '0;
            m_taken  <= 0;
            m_bubble <= 0;
        end else begin
            if (m_br && m_zero && m_valid && !bus.Stall_MEM)
                m_taken <= (m_taken < CNT_MAX) ? m_taken + 1 : CNT_MAX;
            if (bus.Flush_MEM) begin
                {m_alu, m_wdata, m_btgt, m_wreg} <= '0;
                {m_zero, m_rw, m_m2r, m_mr, m_mw, m_br, m_valid} <= '0;
                m_bubble <= (m_bubble < CNT_MAX) ? m_bubble + 1 : CNT_MAX;
            end else if (!bus.Stall_MEM) begin
                m_alu   <= bus.ALU_Result_EX;
                m_zero  <= bus.Zero_EX;
                m_wdata <= bus.Write_Data_EX;
                m_wreg  <= bus.Write_Register_EX;
                m_btgt  <= bus.Branch_Target_EX;
                m_rw    <= bus.RegWrite_EX && (bus.Write_Register_EX != 0);
                m_m2r   <= bus.MemtoReg_EX;
                m_mr    <= bus.MemRead_EX;
                m_mw    <= bus.MemWrite_EX;
                m_br    <= bus.Branch_EX;
                m_valid <= 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        check("alu",     bus.ALU_Result_MEM,     m_alu);
        check("zero",    bus.Zero_MEM,           m_zero);
        check("wdata",   bus.Write_Data_MEM,     m_wdata);
        check("wreg",    bus.Write_Register_MEM, m_wreg);
        check("btgt",    bus.Branch_Target_MEM,  m_btgt);
        check("rw",      bus.RegWrite_MEM,       m_rw);
        check("m2r",     bus.MemtoReg_MEM,       m_m2r);
        check("mr",      bus.MemRead_MEM,        m_mr);
        check("mw",      bus.MemWrite_MEM,       m_mw);
        check("br",      bus.Branch_MEM,         m_br);
        check("valid",   bus.Valid_MEM,          m_valid);
        check("pcsrc",   bus.PCSrc_MEM,          m_br & m_zero & m_valid);
        check("taken",   bus.Taken_Count,        m_taken[CNT_W-1:0]);
        check("bubble",  bus.Bubble_Count,       m_bubble[CNT_W-1:0]);
    end

    // ctl = {RegWrite, MemtoReg, MemRead, MemWrite, Branch}
    task automatic set_ex(input logic [31:0] alu, input logic z, input logic [31:0] wd,
                          input logic [4:0] wr, input logic [31:0] bt, input logic [4:0] ctl);
        bus.ALU_Result_EX     = alu;
        bus.Zero_EX           = z;
        bus.Write_Data_EX     = wd;
        bus.Write_Register_EX = wr;
        bus.Branch_Target_EX  = bt;
        {bus.RegWrite_EX, bus.MemtoReg_EX, bus.MemRead_EX, bus.MemWrite_EX, bus.Branch_EX} = ctl;
    endtask

    // One edge; returns 2 time units after the following negedge.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
        #2;
    endtask

    initial begin
        Reset         = 1'b1;
        bus.Stall_MEM = 1'b0;
        bus.Flush_MEM = 1'b0;
        set_ex(32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 5'b00000);
        @(negedge Clk); #2;
        check("rst_alu",    bus.ALU_Result_MEM, 32'h0);
        check("rst_valid",  bus.Valid_MEM,      1'b0);
        check("rst_pcsrc",  bus.PCSrc_MEM,      1'b0);
        check("rst_taken",  bus.Taken_Count,    4'd0);
        check("rst_bubble", bus.Bubble_Count,   4'd0);

        Reset = 1'b0;
        set_ex(32'h5, 1'b0, 32'hDEAD_BEEF, 5'd8, 32'h0, 5'b10000);
        step();
        check("load_alu",   bus.ALU_Result_MEM,     32'h5);
        check("load_wreg",  bus.Write_Register_MEM, 5'd8);
        check("load_rw",    bus.RegWrite_MEM,       1'b1);
        check("load_valid", bus.Valid_MEM,          1'b1);

        set_ex(32'h0, 1'b1, 32'h0, 5'd0, 32'h0040_0020, 5'b00001);
        step();
        check("br_pcsrc", bus.PCSrc_MEM,         1'b1);
        check("br_btgt",  bus.Branch_Target_MEM, 32'h0040_0020);
        check("br_taken0", bus.Taken_Count,      4'd0);
        set_ex(32'h1234, 1'b0, 32'h0, 5'd9, 32'h0, 5'b10000);
        step();
        check("br_taken1", bus.Taken_Count,    4'd1);
        check("hold_base", bus.ALU_Result_MEM, 32'h1234);

        bus.Stall_MEM = 1'b1;
        set_ex(32'hFFFF, 1'b1, 32'hFFFF, 5'd31, 32'hFFFF, 5'b11111);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_alu", bus.ALU_Result_MEM, 32'h1234);
        end
        bus.Stall_MEM = 1'b0;

        set_ex(32'h0, 1'b1, 32'h0, 5'd0, 32'h100, 5'b00001);
        step();
        check("sbr_pcsrc", bus.PCSrc_MEM, 1'b1);
        bus.Stall_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sbr_taken_hold", bus.Taken_Count, 4'd1);
        end
        bus.Stall_MEM = 1'b0;
        set_ex(32'h7, 1'b0, 32'h0, 5'd2, 32'h0, 5'b10000);
        step();
        check("sbr_taken2", bus.Taken_Count,    4'd2);
        check("sbr_alu",    bus.ALU_Result_MEM, 32'h7);

        bus.Stall_MEM = 1'b1;
        bus.Flush_MEM = 1'b1;
        set_ex(32'h55, 1'b0, 32'h66, 5'd3, 32'h0, 5'b00010);
        step();
        check("flush_mw",     bus.MemWrite_MEM,   1'b0);
        check("flush_valid",  bus.Valid_MEM,      1'b0);
        check("flush_alu",    bus.ALU_Result_MEM, 32'h0);
        check("flush_bubble", bus.Bubble_Count,   4'd1);
        bus.Stall_MEM = 1'b0;
        bus.Flush_MEM = 1'b0;

        set_ex(32'h3, 1'b0, 32'h0, 5'd0, 32'h0, 5'b10000);
        step();
        check("zero_rw",    bus.RegWrite_MEM, 1'b0);
        check("zero_valid", bus.Valid_MEM,    1'b1);

        bus.Flush_MEM = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 13) check("sat_mid", bus.Bubble_Count, 4'd14);
        end
        check("sat_bubble", bus.Bubble_Count, 4'd15);
        bus.Flush_MEM = 1'b0;

        set_ex(32'hAA, 1'b0, 32'h0, 5'd3, 32'h0, 5'b10000);
        step();
        check("pre_rst_alu", bus.ALU_Result_MEM, 32'hAA);
        #1 Reset = 1'b1;
        #1;
        check("arst_alu",    bus.ALU_Result_MEM, 32'h0);
        check("arst_valid",  bus.Valid_MEM,      1'b0);
        check("arst_taken",  bus.Taken_Count,    4'd0);
        check("arst_bubble", bus.Bubble_Count,   4'd0);
        #1 Reset = 1'b0;
        set_ex(32'h42, 1'b0, 32'h0, 5'd4, 32'h0, 5'b10000);
        step();
        check("post_rst_alu",   bus.ALU_Result_MEM, 32'h42);
        check("post_rst_valid", bus.Valid_MEM,      1'b1);

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
